dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Arbitrates one single-port data-memory bank between the processor data port and a host debug port driven from the logic analyzer.
//  Core has priority; a starvation counter forces a host grant after STARVE_MAX consecutive lost cycles.
//  Decodes core byte addresses onto bank rows and stalls the core only when it loses the port.
//  Sits between core datapath and the data_mem_array bank in the memory controller.
// PARAMETERS
//  DATA_W      32  data word width
//  ROW_W       4   bank row index width (10 rows used: 0..9)
//  STARVE_MAX  4   max consecutive host-losing cycles before host forced; 0 = host always wins
// PORTS
//  clk         in   1       system clock, all state on posedge
//  reset       in   1       synchronous, active-high
//  core_req    in   1       core load/store this cycle
//  core_we     in   1       core store
//  core_addr   in   32      core byte address
//  core_wdata  in   DATA_W  core store data
//  core_rdata  out  DATA_W  core load data, combinational
//  core_stall  out  1       core lost arbitration, hold request
//  host_req    in   1       host access request, level, held until host_ack
//  host_we     in   1       host write
//  host_row    in   ROW_W   host row index
//  host_wdata  in   DATA_W  host write data
//  host_rdata  out  DATA_W  registered host read data, valid with host_ack
//  host_ack    out  1       one-cycle completion pulse
//  mem_we      out  1       bank write enable
//  mem_row     out  ROW_W   bank row
//  mem_wdata   out  DATA_W  bank write data
//  mem_rdata   in   DATA_W  bank combinational read data
// BEHAVIOUR
//  Core address map: addr[31:2]<8 -> row addr[31:2]; addr==96 -> row 8; addr==100 -> row 9; else unmapped.
//  Unmapped core access: core_rdata=0, store dropped, never stalls, does not count as contention.
//  Host row >9: read returns 0, write dropped, still acked normally.
//  FSM: S_IDLE, S_ACK. Reset -> S_IDLE, starve_cnt=0, host_ack=0, host_rdata=0.
//  S_IDLE: host_win = host_req && (!core_hit || starve_cnt==STARVE_MAX), core_hit = core_req && mapped.
//   host_win: bank driven by host this cycle, host_rdata<=mem_rdata, starve_cnt<=0, next S_ACK; core_stall=core_hit.
//   else core_hit: bank driven by core, core_rdata=mem_rdata, core_stall=0;
//        if host_req, starve_cnt<=starve_cnt+1 (saturate at STARVE_MAX).
//  S_ACK: host_ack=1, host_req ignored this cycle; core served as in S_IDLE with no contention; next S_IDLE.
//  Host must drop or re-present host_req the cycle after host_ack; new request accepted from S_IDLE.
//  Latency: host uncontended access -> ack 1 cycle later; worst case STARVE_MAX+1 cycles.
//  Core stall never exceeds 1 consecutive cycle per host transaction.
//  No grant: mem_we=0, mem_row=0, mem_wdata=0.
//  mem_we forced 0 while reset is high; reset mid-transaction aborts it: no ack, S_IDLE, counter cleared.
//  Simultaneous core store and host write to same row: grant decides; loser's write lands on its later grant.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_stall_cnt[15:0] (cycles core_stall=1) and stat_host_cnt[15:0] (host grants).
//   Both saturating at 16'hFFFF, cleared by reset.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Shared package dmem_pkg: row constants ROW_96=8, ROW_100=9, NUM_ROWS=10, FSM state encodings.
//  Sub-module dmem_addr_decode: core_addr -> {mapped, row}, pure combinational.
//  Arbiter FSM, starvation counter and optional stats in this module.
// TESTING
//  Host read row 3 (=32'hA5A5_0003), core idle -> host_ack 1 cycle later, host_rdata=32'hA5A5_0003, no stall.
//  Core store addr 96 data 32'h1234 -> mem_we=1, mem_row=8 same cycle; core load addr 96 -> 32'h1234.
//  Core load addr 200 -> core_rdata=0, core_stall=0, mem_we=0.
//  Core hit every cycle + host_req, STARVE_MAX=4 -> 4 core grants, host granted cycle 5, core_stall=1 for that one cycle.
//  Host write row 5 with core store to row 5 same cycle, counter 0 -> core value written first, host value final.
//  Reset during host grant cycle with host_we=1 -> no write, no host_ack, FSM S_IDLE, stats (if ARB_STATS_EN) 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Package: dmem_pkg
// Shared constants for the data-memory port arbiter. It holds the bank row
// map for the two extra core addresses, the bank depth and the encodings of
// the arbiter states.
package dmem_pkg;

    // Bank geometry: rows 0..7 come from word addresses, and two single
    // addresses are folded onto the top rows.
    localparam int NUM_ROWS = 10;
    localparam int ROW_96   = 8;
    localparam int ROW_100  = 9;

    localparam logic [31:0] ADDR_96  = 32'd96;
    localparam logic [31:0] ADDR_100 = 32'd100;

    // Number of word rows reached through a direct addr[31:2] mapping.
    localparam int NUM_WORD_ROWS = 8;

    // Arbiter states.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

endpackage

// File: rtl/dmem_addr_decode.sv
// Module: dmem_addr_decode
// Maps a core byte address onto a bank row. This is purely combinational.
//   addr[31:2] < 8 -> row addr[31:2]
//   addr == 96     -> row 8
//   addr == 100    -> row 9
//   anything else  -> unmapped (mapped=0, row=0)
// Ports:
//   addr    in   32     core byte address
//   mapped  out  1      address hits a bank row
//   row     out  ROW_W  bank row index (0 when unmapped)
module dmem_addr_decode
    import dmem_pkg::*;
#(
    parameter int ROW_W = 4
) (
    input  logic [31:0]      addr,
    output logic             mapped,
    output logic [ROW_W-1:0] row
);

    logic [29:0] word;

    always_comb begin
        word   = addr[31:2];
        mapped = 1'b0;
        row    = '0;
        if (word < 30'(NUM_WORD_ROWS)) begin
            mapped = 1'b1;
            row    = word[ROW_W-1:0];
        end else if (addr == ADDR_96) begin
            mapped = 1'b1;
            row    = ROW_W'(ROW_96);
        end else if (addr == ADDR_100) begin
            mapped = 1'b1;
            row    = ROW_W'(ROW_100);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Module: dmem_port_arbiter
// Shares one single-port data-memory bank between the core data port and a
// host debug port. The core has priority. A starvation counter forces a host
// grant after STARVE_MAX consecutive cycles in which the host lost to the core.
// If STARVE_MAX is 0, the host always wins.
// Optional feature: define ARB_STATS_EN to add the saturating counters
// stat_stall_cnt and stat_host_cnt.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   core_req/we/addr/wdata           core access (byte address)
//   core_rdata, core_stall           core load data (comb), lost-arbitration stall
//   host_req/we/row/wdata            host access (level, held until host_ack)
//   host_rdata, host_ack             registered read data, one-cycle completion
//   mem_we/row/wdata, mem_rdata      bank interface (comb read)
//   stat_stall_cnt, stat_host_cnt    (ARB_STATS_EN only) statistics
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ROW_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ROW_W-1:0]  host_row,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
`ifdef ARB_STATS_EN
    output logic [15:0]       stat_stall_cnt,
    output logic [15:0]       stat_host_cnt,
`endif
    output logic              mem_we,
    output logic [ROW_W-1:0]  mem_row,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The counter width must also be legal when STARVE_MAX is 0.
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic             core_mapped;
    logic [ROW_W-1:0] core_row;
    logic             core_hit, host_win, core_grant, host_row_ok;

    dmem_addr_decode #(.ROW_W(ROW_W)) u_decode (
        .addr   (core_addr),
        .mapped (core_mapped),
        .row    (core_row)
    );

    always_comb begin
        core_hit    = core_req && core_mapped;
        host_row_ok = (host_row < ROW_W'(NUM_ROWS));
        // In S_ACK the host request is stale and is ignored. The core then
        // has the port to itself.
        host_win    = (state_q == S_IDLE) && host_req &&
                      (!core_hit || (starve_cnt_q == STARVE_LIM));
        core_grant  = core_hit && !host_win;
        core_stall  = core_hit && host_win;

        mem_we     = 1'b0;
        mem_row    = '0;
        mem_wdata  = '0;
        core_rdata = '0;
        if (host_win) begin
            // An out-of-range host row leaves the bank idle. The access is
            // still acked, and the read returns 0.
            if (host_row_ok) begin
                mem_we    = host_we;
                mem_row   = host_row;
                mem_wdata = host_wdata;
            end
        end else if (core_grant) begin
            mem_we     = core_we;
            mem_row    = core_row;
            mem_wdata  = core_wdata;
            core_rdata = mem_rdata;
        end
        // The bank is never written while reset is high, even if a grant is
        // decoded from the live inputs.
        if (reset) mem_we = 1'b0;

        state_d      = (state_q == S_ACK) ? S_IDLE : (host_win ? S_ACK : S_IDLE);
        starve_cnt_d = starve_cnt_q;
        host_rdata_d = host_rdata_q;
        if (host_win) begin
            starve_cnt_d = '0;
            host_rdata_d = host_row_ok ? mem_rdata : '0;
        end else if (core_grant && host_req && (state_q == S_IDLE) &&
                     (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign host_ack   = (state_q == S_ACK);
    assign host_rdata = host_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt_q, host_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            host_cnt_q  <= '0;
        end else begin
            if (core_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (host_win && (host_cnt_q != 16'hFFFF))    host_cnt_q  <= host_cnt_q + 16'd1;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_host_cnt  = host_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench: tb_dmem_port_arbiter
// This bench runs directed steps against dmem_port_arbiter with STARVE_MAX=4.
// It uses a 10-row behavioural bank, preloaded with 32'hA5A5_0000 | row.
// Inputs change just after the falling edge. Combinational outputs are
// sampled 1 time unit later. Registered outputs are sampled at the next
// falling edge.
module tb_dmem_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ROW_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req, core_we;
    logic [31:0]       core_addr;
    logic [DATA_W-1:0] core_wdata, core_rdata;
    logic              core_stall;
    logic              host_req, host_we;
    logic [ROW_W-1:0]  host_row;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic              host_ack;
    logic              mem_we;
    logic [ROW_W-1:0]  mem_row;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0]       stat_stall_cnt, stat_host_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(DATA_W), .ROW_W(ROW_W), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_row   (host_row),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
`ifdef ARB_STATS_EN
        .stat_stall_cnt (stat_stall_cnt),
        .stat_host_cnt  (stat_host_cnt),
`endif
        .mem_we     (mem_we),
        .mem_row    (mem_row),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural bank
    logic [DATA_W-1:0] bank [10];
    logic              load_bank;

    always @(posedge clk) begin
        if (load_bank) begin
            for (int i = 0; i < 10; i++) bank[i] <= 32'hA5A5_0000 | i;
        end else if (mem_we && mem_row < 4'd10) begin
            bank[mem_row] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_row < 4'd10) ? bank[mem_row] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic core_set(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
        core_req = req; core_we = we; core_addr = addr; core_wdata = wd;
    endtask

    task automatic host_set(input logic req, input logic we, input logic [3:0] row,
                            input logic [31:0] wd);
        host_req = req; host_we = we; host_row = row; host_wdata = wd;
    endtask

    initial begin
        load_bank = 1'b1;
        reset     = 1'b1;
        core_set(1'b1, 1'b1, 32'd0, 32'hDEAD_0000);   // store attempted during reset
        host_set(1'b0, 1'b0, 4'd0, 32'h0);

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        load_bank = 1'b0;
        chk("reset_host_ack", {31'b0, host_ack}, 32'd0);
        chk("reset_host_rdata", host_rdata, 32'd0);
        reset = 1'b0;
        core_set(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("reset_core_stall", {31'b0, core_stall}, 32'd0);
        chk("idle_mem_row", {28'b0, mem_row}, 32'd0);

        // Uncontended host read of row 3
        @(negedge clk);
        host_set(1'b1, 1'b0, 4'd3, 32'h0);
        #1;
        chk("h3_mem_row", {28'b0, mem_row}, 32'd3);
        chk("h3_ack_early", {31'b0, host_ack}, 32'd0);
        @(negedge clk);
        chk("h3_ack", {31'b0, host_ack}, 32'd1);
        chk("h3_rdata", host_rdata, 32'hA5A5_0003);
        host_set(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        chk("h3_ack_pulse", {31'b0, host_ack}, 32'd0);

        // Host write to out-of-range row 12: bank untouched, still acked, reads 0
        host_set(1'b1, 1'b1, 4'd12, 32'h5555_5555);
        #1;
        chk("h12_mem_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("h12_ack", {31'b0, host_ack}, 32'd1);
        chk("h12_rdata", host_rdata, 32'd0);
        host_set(1'b0, 1'b0, 4'd0, 32'h0);

        // Core store to addr 96 -> row 8, then load it back
        @(negedge clk);
        core_set(1'b1, 1'b1, 32'd96, 32'h1234);
        #1;
        chk("st96_mem_we", {31'b0, mem_we}, 32'd1);
        chk("st96_mem_row", {28'b0, mem_row}, 32'd8);
        chk("st96_mem_wdata", mem_wdata, 32'h1234);
        chk("st96_stall", {31'b0, core_stall}, 32'd0);
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd96, 32'h0);
        #1;
        chk("ld96_rdata", core_rdata, 32'h1234);

        // Address map boundaries
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd100, 32'h0);
        #1;
        chk("ld100_row", {28'b0, mem_row}, 32'd9);
        chk("ld100_rdata", core_rdata, 32'hA5A5_0009);
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd28, 32'h0);
        #1;
        chk("ld28_row", {28'b0, mem_row}, 32'd7);
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd32, 32'h0);
        #1;
        chk("ld32_unmapped", core_rdata, 32'd0);

        // Unmapped store/load at 200: no write, no stall, data 0
        @(negedge clk);
        core_set(1'b1, 1'b1, 32'd200, 32'hFFFF_FFFF);
        #1;
        chk("st200_mem_we", {31'b0, mem_we}, 32'd0);
        chk("st200_stall", {31'b0, core_stall}, 32'd0);
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd200, 32'h0);
        #1;
        chk("ld200_rdata", core_rdata, 32'd0);

        // Starvation: the core hits every cycle and the host waits 4 cycles
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd0, 32'h0);
        host_set(1'b1, 1'b0, 4'd2, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("starve_c%0d_stall", c), {31'b0, core_stall}, 32'd0);
            chk($sformatf("starve_c%0d_row", c), {28'b0, mem_row}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("starve_c5_stall", {31'b0, core_stall}, 32'd1);
        chk("starve_c5_row", {28'b0, mem_row}, 32'd2);
        @(negedge clk);
        chk("starve_ack", {31'b0, host_ack}, 32'd1);
        chk("starve_rdata", host_rdata, 32'hA5A5_0002);
        host_set(1'b0, 1'b0, 4'd0, 32'h0);
        #1;
        chk("ack_core_stall", {31'b0, core_stall}, 32'd0);
        chk("ack_core_rdata", core_rdata, 32'hA5A5_0000);

        // Same-row collision on row 5: the core writes first, the host value is final
        @(negedge clk);
        core_set(1'b1, 1'b1, 32'd20, 32'hBEEF);
        host_set(1'b1, 1'b1, 4'd5, 32'hCAFE);
        #1;
        chk("coll_core_wdata", mem_wdata, 32'hBEEF);
        chk("coll_core_row", {28'b0, mem_row}, 32'd5);
        chk("coll_core_stall", {31'b0, core_stall}, 32'd0);
        @(negedge clk);
        chk("coll_bank_core", bank[5], 32'hBEEF);
        core_set(1'b0, 1'b0, 32'd0, 32'h0);
        #1;
        chk("coll_host_we", {31'b0, mem_we}, 32'd1);
        chk("coll_host_wdata", mem_wdata, 32'hCAFE);
        @(negedge clk);
        chk("coll_ack", {31'b0, host_ack}, 32'd1);
        host_set(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'd20, 32'h0);
        #1;
        chk("coll_final", core_rdata, 32'hCAFE);

`ifdef ARB_STATS_EN
        chk("stat_stall", {16'b0, stat_stall_cnt}, 32'd1);
        chk("stat_host", {16'b0, stat_host_cnt}, 32'd4);
`endif

        // Reset during a host write grant aborts it
        @(negedge clk);
        core_set(1'b0, 1'b0, 32'd0, 32'h0);
        host_set(1'b1, 1'b1, 4'd6, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst_mid_ack", {31'b0, host_ack}, 32'd0);
        chk("rst_mid_rdata", host_rdata, 32'd0);
`ifdef ARB_STATS_EN
        chk("rst_stat_stall", {16'b0, stat_stall_cnt}, 32'd0);
        chk("rst_stat_host", {16'b0, stat_host_cnt}, 32'd0);
`endif
        reset = 1'b0;
        host_set(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        chk("rst_mid_ack2", {31'b0, host_ack}, 32'd0);
        core_set(1'b1, 1'b0, 32'd24, 32'h0);
        #1;
        chk("rst_mid_row6", core_rdata, 32'hA5A5_0006);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
